// File: rtl/timer_multi_if.sv
// CPU-side register bus of the multi-channel timer: single-cycle access strobe plus the combined IRQ line.
// Handshake: cs is a one-cycle access strobe. There is no ready signal, so every edge with cs=1 completes
// exactly one access: a write when we=1, or a read when we=0. A read's data appears on dout after that
// edge and stays there until the next read.
interface timer_multi_if #(
    parameter int ADDR_W = 4
);
    logic              cs;
    logic              we;
    logic [ADDR_W-1:0] addr;
    logic [7:0]        din;
    logic [7:0]        dout;
    logic              irq;

    modport master (output cs, output we, output addr, output din, input dout, input irq);
    modport slave  (input cs, input we, input addr, input din, output dout, output irq);
endinterface

// File: rtl/timer_multi.sv
// Parametrised multi-channel down-counting timer with per-channel prescaler select, one-shot/auto-reload and maskable IRQ.
// Optional macro TIMER_LATCH_EN: a LO read snapshots count[15:8] so that the following HI read is tear-free.
module timer_multi #(
    parameter int CHANNELS = 4,
    parameter int WIDTH    = 16,
    parameter int PRESCALE = 16,
    parameter int ADDR_W   = $clog2(CHANNELS) + 2
) (
    input logic          clk,
    input logic          rst,
    timer_multi_if.slave bus
);
    localparam int PS_W = $clog2(PRESCALE);
    localparam logic [PS_W-1:0] PS_MAX = PS_W'(PRESCALE - 1);

    logic [PS_W-1:0]     pre_cnt;
    logic                pre_tick;
    logic [WIDTH-1:0]    count  [CHANNELS];
    logic [WIDTH-1:0]    reload [CHANNELS];
    logic [15:0]         cnt16  [CHANNELS];
    logic [15:0]         rl16   [CHANNELS];
    logic [CHANNELS-1:0] en, auto_rl, irq_en, pre_sel, flag, run;
    logic [CHANNELS-1:0] sel_wr, ctrl_wr, start, stop, sts_clr, tick;
    logic [7:0]          ch_idx;
    logic [1:0]          reg_sel;
    logic                wr_acc, rd_acc;
    logic [7:0]          rdata;
    logic [7:0]          dout_q;
    logic                irq_q;
`ifdef TIMER_LATCH_EN
    logic [7:0]          latch [CHANNELS];
`endif

    assign ch_idx   = 8'(bus.addr >> 2);
    assign reg_sel  = bus.addr[1:0];
    assign wr_acc   = bus.cs & bus.we;
    assign rd_acc   = bus.cs & ~bus.we;
    assign pre_tick = (pre_cnt == PS_MAX);
    assign bus.dout = dout_q;
    assign bus.irq  = irq_q;

    always_comb begin
        sel_wr  = '0;
        ctrl_wr = '0;
        start   = '0;
        stop    = '0;
        sts_clr = '0;
        tick    = '0;
        for (int c = 0; c < CHANNELS; c++) begin
            cnt16[c]   = 16'(count[c]);
            rl16[c]    = 16'(reload[c]);
            sel_wr[c]  = wr_acc && (ch_idx == 8'(c));
            ctrl_wr[c] = sel_wr[c] && (reg_sel == 2'd2);
            // Only an EN 0->1 transition reloads; rewriting CTRL with EN=1 just updates the mode bits.
            start[c]   = ctrl_wr[c] && bus.din[0] && !en[c];
            stop[c]    = ctrl_wr[c] && !bus.din[0];
            sts_clr[c] = sel_wr[c] && (reg_sel == 2'd3) && bus.din[0];
            tick[c]    = pre_sel[c] ? pre_tick : 1'b1;
        end
    end

    always_comb begin
        rdata = '0;
        for (int c = 0; c < CHANNELS; c++) begin
            if (ch_idx == 8'(c)) begin
                case (reg_sel)
                    2'd0: rdata = cnt16[c][7:0];
`ifdef TIMER_LATCH_EN
                    2'd1: rdata = latch[c];
`else
                    2'd1: rdata = cnt16[c][15:8];
`endif
                    2'd2: rdata = {4'b0, pre_sel[c], irq_en[c], auto_rl[c], en[c]};
                    default: rdata = {6'b0, run[c], flag[c]};
                endcase
            end
        end
    end

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            pre_cnt <= '0;
        end else if (pre_cnt == PS_MAX) begin
            pre_cnt <= '0;
        end else begin
            pre_cnt <= pre_cnt + PS_W'(1);
        end
    end

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            for (int c = 0; c < CHANNELS; c++) begin
                count[c]  <= '0;
                reload[c] <= '0;
            end
            en      <= '0;
            auto_rl <= '0;
            irq_en  <= '0;
            pre_sel <= '0;
            flag    <= '0;
            run     <= '0;
        end else begin
            for (int c = 0; c < CHANNELS; c++) begin
                if (sel_wr[c] && reg_sel == 2'd0) reload[c] <= WIDTH'({rl16[c][15:8], bus.din});
                if (sel_wr[c] && reg_sel == 2'd1) reload[c] <= WIDTH'({bus.din, rl16[c][7:0]});
                if (ctrl_wr[c]) begin
                    en[c]      <= bus.din[0];
                    auto_rl[c] <= bus.din[1];
                    irq_en[c]  <= bus.din[2];
                    pre_sel[c] <= bus.din[3];
                end
                if (sts_clr[c]) flag[c] <= 1'b0;
                if (start[c]) begin
                    count[c] <= reload[c];
                    run[c]   <= 1'b1;
                end else if (stop[c]) begin
                    run[c] <= 1'b0;
                end else if (run[c] && tick[c]) begin
                    if (count[c] != '0) begin
                        count[c] <= count[c] - WIDTH'(1);
                    end else begin
                        // Expiry is placed after the STATUS clear so a same-edge set wins.
                        flag[c] <= 1'b1;
                        if (auto_rl[c]) begin
                            count[c] <= reload[c];
                        end else begin
                            run[c] <= 1'b0;
                            en[c]  <= 1'b0;
                        end
                    end
                end
            end
        end
    end

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            dout_q <= '0;
            irq_q  <= 1'b0;
        end else begin
            if (rd_acc) dout_q <= rdata;
            irq_q <= |(flag & irq_en);
        end
    end

`ifdef TIMER_LATCH_EN
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            for (int c = 0; c < CHANNELS; c++) latch[c] <= '0;
        end else begin
            for (int c = 0; c < CHANNELS; c++) begin
                if (rd_acc && ch_idx == 8'(c) && reg_sel == 2'd0) latch[c] <= cnt16[c][15:8];
            end
        end
    end
`endif
endmodule

// File: doc/timer_multi.md
Name: timer_multi

Overview:
- Parametrised multi-channel down-counting timer for the 6502 system bus.
- Successor to the single system timer: N independent channels, configurable counter width, per-channel prescaler select, auto-reload/one-shot modes, and a combined maskable IRQ line.
- Sits beside the uart and ROM on the CPU's 8-bit data bus.
- Drives the CPU IRQ input.

Parameters:
- CHANNELS, 4, number of independent timer channels (1..8).
- WIDTH, 16, counter/reload width in bits (1..16); bits above WIDTH are written as ignored and read as 0.
- PRESCALE, 16, global prescaler divide ratio (>=2); produces a one-cycle tick every PRESCALE clocks.
- ADDR_W, clog2(CHANNELS)+2, register address width.

Ports:
- clk  input  1  system clock; all state on rising edge.
- rst  input  1  asynchronous, active-low reset (asserted when 0).
- cs  input  1  chip select; an access occurs on a clk edge with cs=1.
- we  input  1  1=write, 0=read (qualified by cs).
- addr  input  ADDR_W  register address: addr[ADDR_W-1:2]=channel, addr[1:0]=register.
- din  input  8  write data.
- dout  output  8  read data, registered.
- irq  output  1  OR over channels of (flag & irq_en), registered.

Behaviour:
- Reset (rst=0, async): all counts, reload, ctrl and flags are 0; prescaler is 0; dout=0; irq=0.
  - Release is synchronous to the next clk edge.
  - Reset mid-count aborts all channels with no flag set.
- Registers per channel:
  - 0 = LO: write sets reload[7:0]; read returns count[7:0].
  - 1 = HI: write sets reload[15:8] (masked to WIDTH); read returns count[15:8].
  - 2 = CTRL (rw):
    - bit0 EN
    - bit1 AUTO (1=auto-reload, 0=one-shot)
    - bit2 IRQ_EN
    - bit3 PRE (1=count on prescaler tick, 0=count every clk)
    - bits7:4 read 0
  - 3 = STATUS: read bit0=FLAG, bit1=RUN, others 0; write bit0=1 clears FLAG, other bits ignored.
  - A channel index >= CHANNELS: writes ignored, reads return 0.
- Read latency: dout is updated on the edge where cs=1, we=0, and holds until the next read.
- Start: a CTRL write with EN 0->1 loads count<=reload and sets RUN in that same edge. Counting begins at the following tick.
- Rewriting CTRL with EN already 1 does not reload.
- Tick: every clk when PRE=0; when PRE=1, the cycle where the prescaler equals PRESCALE-1.
  - The prescaler counts 0..PRESCALE-1 free-running and wraps to 0.
- On a tick with RUN=1:
  - If count!=0: count<=count-1.
  - If count==0 (expiry): FLAG<=1.
    - AUTO=1: count<=reload and RUN stays 1.
    - AUTO=0: RUN<=0, EN<=0, count stays 0.
  - Period is reload+1 ticks. reload=0 with AUTO expires on every tick.
- EN written 0 while running: RUN<=0 immediately; count freezes; FLAG unchanged.
- Writing LO/HI while running changes only reload; it takes effect at the next reload or start.
- Simultaneous FLAG set (expiry) and STATUS clear write on the same edge: set wins, FLAG=1.
- irq is registered: it rises 1 clk after a FLAG becomes set while IRQ_EN=1, and falls 1 clk after the last enabled FLAG clears or its IRQ_EN clears.
- Channels are fully independent. Multiple channels expiring on the same edge each set their own FLAG.

Optional Feature:
- TIMER_LATCH_EN defined: a read of LO also snapshots count[15:8] of that channel into a per-channel latch. A subsequent HI read returns the latch, giving tear-free 16-bit reads. The latch resets to 0.
- Undefined: HI returns the live count[15:8]. No latch flops exist.

Test Plan:
- Reset: drive rst=0 mid-count with channel 0 running at count 0x0123 -> all reads return 0x00 and irq=0 after release.
- One-shot: ch0 reload=0x0005, CTRL=0x05 (EN, IRQ_EN, PRE=0) -> FLAG set exactly 6 clks after the start edge, RUN=0, count=0, irq=1 one clk later; STATUS write 0x01 -> irq=0 one clk after.
- Auto-reload with prescaler, PRESCALE=16: ch1 reload=0x0002, CTRL=0x0B -> FLAG sets every 48 clks. Clear it between expiries and check the period is stable across 3 expiries.
- Simultaneous clear/expiry: write STATUS=0x01 on the exact expiry edge of ch2 -> FLAG reads 1 afterwards.
- Multi-channel/IRQ mask: ch0 and ch3 both expire; only ch3 has IRQ_EN -> irq follows ch3's FLAG only, ch0 FLAG readable as 1; address with channel index >= CHANNELS reads 0x00.
- TIMER_LATCH_EN: count 0x0100 decrementing per clk; read LO (0x00 or 0xFF) then HI 2 clks later -> HI matches the snapshot (0x01 if LO=0x00). Without the macro, HI is the live value.
